// File: rtl/y86_execute_stage_p_if.sv
// Decode-to-execute bus for the Y86-64 execute stage: D/d inputs, pipeline control, E/e outputs and flags.
interface y86_execute_stage_p_if #(
   parameter int unsigned W = 64
);
   logic [3:0]   D_stat, D_icode, D_ifun;
   logic [W-1:0] D_valC, d_valA, d_valB;
   logic [3:0]   d_dstE, d_dstM, d_srcA, d_srcB;
   logic         E_stall, E_bubble;
   logic [3:0]   m_stat, W_stat;

   logic [3:0]   E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [W-1:0] E_valC, E_valA, E_valB;
   logic [W-1:0] e_valE;
   logic         e_Cnd;
   logic [3:0]   e_dstE;
   logic         cc_zf, cc_sf, cc_of;
   logic         e_busy;

   modport master (
      output D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB,
             d_dstE, d_dstM, d_srcA, d_srcB, E_stall, E_bubble, m_stat, W_stat,
      input  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
             E_valC, E_valA, E_valB, e_valE, e_Cnd, e_dstE, cc_zf, cc_sf, cc_of, e_busy
   );

   modport slave (
      input  D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB,
             d_dstE, d_dstM, d_srcA, d_srcB, E_stall, E_bubble, m_stat, W_stat,
      output E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
             E_valC, E_valA, E_valB, e_valE, e_Cnd, e_dstE, cc_zf, cc_sf, cc_of, e_busy
   );
endinterface

// File: rtl/y86_execute_stage_p.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes, cmov/jump condition
// and an iterative MUL_R-bits-per-cycle signed multiplier for mulq.
module y86_execute_stage_p #(
   parameter int unsigned W      = 64,
   parameter int unsigned MUL_EN = 1,
   parameter int unsigned MUL_R  = 4
) (
   input logic clk,
   input logic rst_n,
   y86_execute_stage_p_if.slave bus
);
   localparam int unsigned N  = W / MUL_R;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] C_PLUS8  = W'(8);
   localparam logic [W-1:0] C_MINUS8 = ~W'(7);
   localparam logic [3:0]   RNONE    = 4'hF;

   logic [3:0]   r_stat, r_icode, r_ifun, r_dstE, r_dstM, r_srcA, r_srcB;
   logic [W-1:0] r_valC, r_valA, r_valB;
   logic         r_zf, r_sf, r_of, r_cc_done;
   logic [CW-1:0]  r_cnt;
   logic [2*W-1:0] r_acc;

   logic [W-1:0]   w_alu_a, w_alu_b, w_sum, w_dif, w_res, w_b_sh;
   logic           w_of, w_is_op, w_is_mul, w_op_ok, w_last, w_busy, w_hold, w_cc_upd, w_cnd, w_lt;
   logic [MUL_R-1:0] w_chunk;
   logic [MUL_R:0]   w_chunk_s;
   logic [31:0]      w_shamt;
   logic [2*W-1:0]   w_a_ext, w_b_ext, w_term, w_prod;
   logic             w_prod_of;

   // Operand select
   always_comb begin
      w_alu_a = '0;
      w_alu_b = '0;
      case (r_icode)
         4'h2:       w_alu_a = r_valA;
         4'h3:       w_alu_a = r_valC;
         4'h4, 4'h5: begin w_alu_a = r_valC;   w_alu_b = r_valB; end
         4'h6:       begin w_alu_a = r_valA;   w_alu_b = r_valB; end
         4'hC:       begin w_alu_a = r_valC;   w_alu_b = r_valB; end
         4'h8, 4'hA: begin w_alu_a = C_MINUS8; w_alu_b = r_valB; end
         4'h9, 4'hB: begin w_alu_a = C_PLUS8;  w_alu_b = r_valB; end
         default: ;
      endcase
   end

   // Multiplier: accumulate valA * chunk(valB) per cycle; the top chunk carries negative weight
   assign w_last    = (r_cnt == CW'(N - 1));
   assign w_shamt   = 32'(r_cnt) * MUL_R;
   assign w_b_sh    = r_valB >> w_shamt;
   assign w_chunk   = w_b_sh[MUL_R-1:0];
   assign w_chunk_s = w_last ? {w_chunk[MUL_R-1], w_chunk} : {1'b0, w_chunk};
   assign w_a_ext   = {{W{r_valA[W-1]}}, r_valA};
   assign w_b_ext   = {{(2*W-MUL_R-1){w_chunk_s[MUL_R]}}, w_chunk_s};
   assign w_term    = (w_a_ext * w_b_ext) << w_shamt;
   assign w_prod    = r_acc + w_term;
   assign w_prod_of = (w_prod[2*W-1:W] != {W{w_prod[W-1]}});

   assign w_is_op  = (r_icode == 4'h6);
   assign w_is_mul = w_is_op && (r_ifun == 4'h4) && (MUL_EN != 0);
   assign w_op_ok  = !w_is_op || (r_ifun < 4'h4) || w_is_mul;
   assign w_busy   = w_is_mul && !w_last;
   assign w_hold   = bus.E_stall || w_busy;
   assign w_sum    = w_alu_b + w_alu_a;
   assign w_dif    = w_alu_b - w_alu_a;

   // ALU function and overflow
   always_comb begin
      w_res = w_sum;
      w_of  = (w_alu_a[W-1] == w_alu_b[W-1]) && (w_sum[W-1] != w_alu_a[W-1]);
      if (w_is_op) begin
         case (r_ifun)
            4'h0: ;
            4'h1: begin
               w_res = w_dif;
               w_of  = (w_alu_a[W-1] != w_alu_b[W-1]) && (w_dif[W-1] != w_alu_b[W-1]);
            end
            4'h2: begin w_res = w_alu_a & w_alu_b; w_of = 1'b0; end
            4'h3: begin w_res = w_alu_a ^ w_alu_b; w_of = 1'b0; end
            default: begin
               w_res = w_is_mul ? w_prod[W-1:0] : '0;
               w_of  = w_is_mul && w_prod_of;
            end
         endcase
      end
   end

   assign w_cc_upd = ((r_icode == 4'h6) || (r_icode == 4'hC)) && !w_busy && w_op_ok &&
                     (bus.m_stat == 4'h1) && (bus.W_stat == 4'h1) && !r_cc_done;

   // Condition evaluation for cmovXX / jXX
   assign w_lt = r_sf ^ r_of;
   always_comb begin
      w_cnd = 1'b0;
      if ((r_icode == 4'h2) || (r_icode == 4'h7)) begin
         case (r_ifun)
            4'h0: w_cnd = 1'b1;
            4'h1: w_cnd = w_lt | r_zf;
            4'h2: w_cnd = w_lt;
            4'h3: w_cnd = r_zf;
            4'h4: w_cnd = ~r_zf;
            4'h5: w_cnd = ~w_lt;
            4'h6: w_cnd = ~w_lt & ~r_zf;
            default: w_cnd = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat <= 4'h1; r_icode <= 4'h1; r_ifun <= 4'h0;
         r_dstE <= RNONE; r_dstM <= RNONE; r_srcA <= RNONE; r_srcB <= RNONE;
         r_valC <= '0; r_valA <= '0; r_valB <= '0;
         r_zf <= 1'b1; r_sf <= 1'b0; r_of <= 1'b0; r_cc_done <= 1'b0;
         r_cnt <= '0; r_acc <= '0;
      end else begin
         if (w_cc_upd) begin
            r_zf <= (w_res == '0);
            r_sf <= w_res[W-1];
            r_of <= w_of;
         end
         // A held instruction updates CC only on its first eligible edge
         r_cc_done <= w_hold ? (r_cc_done | w_cc_upd) : 1'b0;
         if (w_busy) begin
            r_cnt <= r_cnt + CW'(1);
            r_acc <= w_prod;
         end else if (!bus.E_stall) begin
            r_cnt <= '0;
            r_acc <= '0;
         end
         if (!w_hold) begin
            if (bus.E_bubble) begin
               r_stat <= 4'h1; r_icode <= 4'h1; r_ifun <= 4'h0;
               r_dstE <= RNONE; r_dstM <= RNONE; r_srcA <= RNONE; r_srcB <= RNONE;
               r_valC <= '0; r_valA <= '0; r_valB <= '0;
            end else begin
               r_stat <= bus.D_stat; r_icode <= bus.D_icode; r_ifun <= bus.D_ifun;
               r_dstE <= bus.d_dstE; r_dstM <= bus.d_dstM; r_srcA <= bus.d_srcA; r_srcB <= bus.d_srcB;
               r_valC <= bus.D_valC; r_valA <= bus.d_valA; r_valB <= bus.d_valB;
            end
         end
      end
   end

   assign bus.E_stat  = r_stat;  assign bus.E_icode = r_icode; assign bus.E_ifun = r_ifun;
   assign bus.E_dstE  = r_dstE;  assign bus.E_dstM  = r_dstM;
   assign bus.E_srcA  = r_srcA;  assign bus.E_srcB  = r_srcB;
   assign bus.E_valC  = r_valC;  assign bus.E_valA  = r_valA;  assign bus.E_valB = r_valB;
   assign bus.e_valE  = w_res;
   assign bus.e_Cnd   = w_cnd;
   assign bus.e_dstE  = ((r_icode == 4'h2) && !w_cnd) ? RNONE : r_dstE;
   assign bus.cc_zf   = r_zf;    assign bus.cc_sf   = r_sf;    assign bus.cc_of  = r_of;
   assign bus.e_busy  = w_busy;
endmodule

// File: tb/tb_y86_execute_stage_p.sv
// Randomised and directed check of y86_execute_stage_p (W=64, MUL_R=4) against a behavioural model.
module tb_y86_execute_stage_p;
   localparam int unsigned W = 64;
   localparam int N = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   y86_execute_stage_p_if #(.W(W)) bus ();
   y86_execute_stage_p #(.W(W), .MUL_EN(1), .MUL_R(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_total = 0;
   int n_bad   = 0;

   // Model state
   logic [3:0]  m_stat, m_icode, m_ifun, m_dstE, m_dstM, m_srcA, m_srcB;
   logic [63:0] m_valC, m_valA, m_valB;
   logic        m_zf, m_sf, m_of, m_done;
   int          m_age;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_stat = 4'h1; m_icode = 4'h1; m_ifun = 4'h0;
      m_dstE = 4'hF; m_dstM = 4'hF; m_srcA = 4'hF; m_srcB = 4'hF;
      m_valC = '0; m_valA = '0; m_valB = '0;
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_done = 1'b0; m_age = 0;
   endtask

   function automatic void alu_ref(output logic [63:0] res, output logic of, output logic ok);
      logic [63:0]  a, b;
      logic [64:0]  s;
      logic [127:0] p;
      a = 64'd0; b = 64'd0; ok = 1'b1; of = 1'b0;
      case (m_icode)
         4'h2: a = m_valA;
         4'h3: a = m_valC;
         4'h4, 4'h5, 4'hC: begin a = m_valC; b = m_valB; end
         4'h6: begin a = m_valA; b = m_valB; end
         4'h8, 4'hA: begin a = 64'hFFFF_FFFF_FFFF_FFF8; b = m_valB; end
         4'h9, 4'hB: begin a = 64'd8; b = m_valB; end
         default: ;
      endcase
      s = {a[63], a} + {b[63], b};
      res = s[63:0]; of = s[64] ^ s[63];
      if (m_icode == 4'h6) begin
         case (m_ifun)
            4'h0: ;
            4'h1: begin s = {b[63], b} - {a[63], a}; res = s[63:0]; of = s[64] ^ s[63]; end
            4'h2: begin res = a & b; of = 1'b0; end
            4'h3: begin res = a ^ b; of = 1'b0; end
            4'h4: begin
               p = {{64{b[63]}}, b} * {{64{a[63]}}, a};
               res = p[63:0]; of = (p[127:64] != {64{p[63]}});
            end
            default: begin res = 64'd0; of = 1'b0; ok = 1'b0; end
         endcase
      end
   endfunction

   function automatic logic cond_ref();
      logic lt;
      lt = m_sf ^ m_of;
      if (m_icode != 4'h2 && m_icode != 4'h7) return 1'b0;
      case (m_ifun)
         4'h0: return 1'b1;
         4'h1: return lt | m_zf;
         4'h2: return lt;
         4'h3: return m_zf;
         4'h4: return !m_zf;
         4'h5: return !lt;
         4'h6: return !lt && !m_zf;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic busy_ref();
      return (m_icode == 4'h6) && (m_ifun == 4'h4) && (m_age < N - 1);
   endfunction

   task automatic check_all();
      logic [63:0] res; logic of, ok, c;
      alu_ref(res, of, ok);
      c = cond_ref();
      chk("E_stat", 64'(bus.E_stat), 64'(m_stat));
      chk("E_icode", 64'(bus.E_icode), 64'(m_icode));
      chk("E_ifun", 64'(bus.E_ifun), 64'(m_ifun));
      chk("E_dst", 64'({bus.E_dstE, bus.E_dstM}), 64'({m_dstE, m_dstM}));
      chk("E_src", 64'({bus.E_srcA, bus.E_srcB}), 64'({m_srcA, m_srcB}));
      chk("E_valC", bus.E_valC, m_valC);
      chk("E_valA", bus.E_valA, m_valA);
      chk("E_valB", bus.E_valB, m_valB);
      chk("e_busy", 64'(bus.e_busy), 64'(busy_ref()));
      if (!busy_ref()) chk("e_valE", bus.e_valE, res);
      chk("e_Cnd", 64'(bus.e_Cnd), 64'(c));
      chk("e_dstE", 64'(bus.e_dstE), 64'((m_icode == 4'h2 && !c) ? 4'hF : m_dstE));
      chk("cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'({m_zf, m_sf, m_of}));
   endtask

   // Advance the model by one clock edge using the inputs currently applied
   task automatic model_step();
      logic [63:0] res; logic of, ok, busy, upd;
      alu_ref(res, of, ok);
      busy = busy_ref();
      upd = (m_icode == 4'h6 || m_icode == 4'hC) && !busy && ok &&
            bus.m_stat == 4'h1 && bus.W_stat == 4'h1 && !m_done;
      if (upd) begin m_zf = (res == 64'd0); m_sf = res[63]; m_of = of; end
      if (bus.E_stall || busy) begin
         if (busy) m_age++;
         m_done = m_done | upd;
      end else begin
         m_age = 0; m_done = 1'b0;
         if (bus.E_bubble) begin
            m_stat = 4'h1; m_icode = 4'h1; m_ifun = 4'h0;
            m_dstE = 4'hF; m_dstM = 4'hF; m_srcA = 4'hF; m_srcB = 4'hF;
            m_valC = '0; m_valA = '0; m_valB = '0;
         end else begin
            m_stat = bus.D_stat; m_icode = bus.D_icode; m_ifun = bus.D_ifun;
            m_dstE = bus.d_dstE; m_dstM = bus.d_dstM; m_srcA = bus.d_srcA; m_srcB = bus.d_srcB;
            m_valC = bus.D_valC; m_valA = bus.d_valA; m_valB = bus.d_valB;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                      input logic [63:0] a, input logic [63:0] b, input logic [3:0] de);
      bus.D_stat = 4'h1; bus.D_icode = ic; bus.D_ifun = fn;
      bus.D_valC = c; bus.d_valA = a; bus.d_valB = b;
      bus.d_dstE = de; bus.d_dstM = 4'hF; bus.d_srcA = 4'h1; bus.d_srcB = 4'h2;
      bus.E_stall = 1'b0; bus.E_bubble = 1'b0; bus.m_stat = 4'h1; bus.W_stat = 4'h1;
   endtask

   function automatic logic [63:0] rnd_val();
      case ($urandom_range(0, 4))
         0: return 64'd0;
         1: return 64'h7FFF_FFFF_FFFF_FFFF;
         2: return 64'(32'($urandom_range(0, 20))) - 64'd10;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int bc;
      rst_n = 1'b0;
      drv(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) tick();
      chk("rst_icode", 64'(bus.E_icode), 64'd1);
      chk("rst_dstE", 64'(bus.e_dstE), 64'hF);
      chk("rst_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b100);
      chk("rst_busy", 64'(bus.e_busy), 64'd0);

      // Signed overflow on add
      drv(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h3); tick();
      chk("add_ovf_val", bus.e_valE, 64'h8000_0000_0000_0000);
      drv(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF); tick();
      chk("add_ovf_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b011);

      // subq equal, then cmovne / cmove
      drv(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h3); tick();
      drv(4'h2, 4'h4, 64'd0, 64'd9, 64'd0, 4'h4); tick();
      chk("cmovne_cnd", 64'(bus.e_Cnd), 64'd0);
      chk("cmovne_dst", 64'(bus.e_dstE), 64'hF);
      drv(4'h2, 4'h3, 64'd0, 64'd9, 64'd0, 4'h4); tick();
      chk("cmove_cnd", 64'(bus.e_Cnd), 64'd1);
      chk("cmove_dst", 64'(bus.e_dstE), 64'h4);

      // CC frozen while downstream is not AOK
      drv(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h3); tick();
      drv(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF); bus.m_stat = 4'h3; tick();
      chk("frozen_zf", 64'(bus.cc_zf), 64'd1);
      drv(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h3); tick();
      drv(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF); tick();
      chk("upd_zf", 64'(bus.cc_zf), 64'd0);

      // mulq -3*5 with E_bubble asserted throughout
      drv(4'h6, 4'h4, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 4'h5); tick();
      drv(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF); bus.E_bubble = 1'b1;
      bc = 0;
      for (int i = 0; i < 20 && bus.e_busy; i++) begin bc++; tick(); end
      chk("mul_busy_cycles", 64'(bc), 64'd15);
      chk("mul_icode", 64'(bus.E_icode), 64'd6);
      chk("mul_val", bus.e_valE, 64'hFFFF_FFFF_FFFF_FFF1);
      tick();
      chk("mul_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b010);

      drv(4'h6, 4'h4, 64'd0, 64'h1_0000_0000, 64'h1_0000_0000, 4'h5); tick();
      drv(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
      for (int i = 0; i < 20 && bus.e_busy; i++) tick();
      chk("mul_big_val", bus.e_valE, 64'd0);
      tick();
      chk("mul_big_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b101);

      // Reset in the middle of a mulq
      drv(4'h6, 4'h4, 64'd0, 64'd7, 64'd7, 4'h5); tick();
      drv(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
      repeat (6) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mul_icode", 64'(bus.E_icode), 64'd1);
      chk("rst_mul_busy", 64'(bus.e_busy), 64'd0);
      chk("rst_mul_cc", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b100);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         logic [3:0] ic;
         ic = 4'($urandom_range(0, 12));
         drv(ic, (ic == 4'h6) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 7)),
             rnd_val(), rnd_val(), rnd_val(), 4'($urandom_range(0, 15)));
         bus.D_stat   = 4'($urandom_range(1, 4));
         bus.d_dstM   = 4'($urandom_range(0, 15));
         bus.d_srcA   = 4'($urandom_range(0, 15));
         bus.d_srcB   = 4'($urandom_range(0, 15));
         bus.E_stall  = ($urandom_range(0, 7) == 0);
         bus.E_bubble = ($urandom_range(0, 7) == 0);
         bus.m_stat   = ($urandom_range(0, 5) == 0) ? 4'h2 : 4'h1;
         bus.W_stat   = ($urandom_range(0, 5) == 0) ? 4'h3 : 4'h1;
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
